pwm_sd_dac: RTL and testbench

Converts a 14-bit signed DSP-bus value (the `pwm0`/`pwm1` routing outputs of the DSP router) into a single-bit PWM stream for the slow analog outputs.
- **PWM core:** an 8-bit coarse duty cycle is generated over a fixed 256-cycle period.
- **Dither:** the 6 remaining LSBs are spread across a 64-period frame by first-order sigma-delta dithering, so the average duty cycle resolves all 14 bits.
- **Placement:** one instance per PWM channel, directly downstream of the DSP router, driving the FPGA pin registers.

---
 rtl/pwm_sd_dac.sv | 174 +++++++++++++++++
 tb/tb_pwm_sd_dac.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sd_dac.sv
// pwm_sd_dac: 14-bit signed sample to single-bit PWM stream.
// An 8-bit coarse duty runs over a 256-cycle period. The 6 fine LSBs are
// spread over a 64-period frame by a first-order sigma-delta accumulator.
// Build option: define PWM_SD_DITHER_EN to enable the sigma-delta dither.
// Without it the fine bits are ignored and the duty tops out at 255/256.
// Handshake: none. dat_i is sampled once per period, in the cycle where
// the counter holds its terminal value; sync_i low holds everything cleared.
module pwm_sd_dac #(
   parameter int DW = 14,
   parameter int CW = 8,
   parameter int FW = DW - CW
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [DW-1:0] dat_i,
   input  logic          sync_i,
   output logic          pwm_o,
   output logic          period_o,
   output logic [CW:0]   duty_o
);

   // ---------------------------------------------------------------
   // Common decode
   // ---------------------------------------------------------------

   // Reset and a low run enable have the same clearing effect.
   logic clear;
   assign clear = rst_i | ~sync_i;

   // Offset-binary view of the signed sample: flip the sign bit.
   logic [DW-1:0] u;
   assign u = {~dat_i[DW-1], dat_i[DW-2:0]};

   logic [CW-1:0] coarse;
   assign coarse = u[DW-1:FW];

   // ---------------------------------------------------------------
   // Period counter
   // ---------------------------------------------------------------
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          boundary;

   // Last cycle of the period: the only cycle in which dat_i is sampled.
   assign boundary = (cnt_q == {CW{1'b1}});

   // Free-running counter, held at zero while cleared.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // Dither carry
   // ---------------------------------------------------------------
   logic carry;

`ifdef PWM_SD_DITHER_EN
   logic [FW-1:0] fine;
   logic [FW:0]   sum;
   logic [FW-1:0] acc_q;
   logic [FW-1:0] acc_d;

   assign fine  = u[FW-1:0];
   assign sum   = {1'b0, acc_q} + {1'b0, fine};
   assign carry = sum[FW];

   // Accumulator advances by the fine value once per period; overflow
   // becomes the extra duty step for the next period.
   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (boundary) begin
         acc_d = sum[FW-1:0];
      end
   end

   // Accumulator register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   // Fine bits carry no meaning in this build.
   logic unused_fine;
   assign unused_fine = ^u[FW-1:0];
   assign carry       = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Duty register
   // ---------------------------------------------------------------
   // CW+1 bits wide so that coarse = max plus a carry reaches a full
   // period of high output; no saturation is needed.
   logic [CW:0] duty_q;
   logic [CW:0] duty_d;

   // Duty is loaded at the period boundary and held for a whole period.
   always_comb begin
      duty_d = duty_q;
      if (clear) begin
         duty_d = '0;
      end else if (boundary) begin
         duty_d = {1'b0, coarse} + {{CW{1'b0}}, carry};
      end
   end

   // Duty register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         duty_q <= '0;
      end else begin
         duty_q <= duty_d;
      end
   end

   // ---------------------------------------------------------------
   // Output stage
   // ---------------------------------------------------------------
   logic pwm_q;
   logic pwm_d;
   logic period_q;
   logic period_d;

   // Compare and period decode; both go through one register so the
   // period strobe lines up with the first PWM bit of each period.
   always_comb begin
      pwm_d    = ({1'b0, cnt_q} < duty_q);
      period_d = (cnt_q == '0);
      if (clear) begin
         pwm_d    = 1'b0;
         period_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_q    <= 1'b0;
         period_q <= 1'b0;
      end else begin
         pwm_q    <= pwm_d;
         period_q <= period_d;
      end
   end

   assign pwm_o    = pwm_q;
   assign period_o = period_q;

`ifdef PWM_SD_DITHER_EN
   assign duty_o = duty_q;
`else
   // Top bit can never be set without a carry; tie it off explicitly.
   assign duty_o = {1'b0, duty_q[CW-1:0]};
   logic unused_duty_msb;
   assign unused_duty_msb = duty_q[CW];
`endif

endmodule

// File: tb/tb_pwm_sd_dac.sv
// tb_pwm_sd_dac: directed scenarios plus randomized stimulus for pwm_sd_dac,
// checked cycle by cycle against an arithmetic reference model and with
// per-period aggregate checks (high counts, duty readback, frame sums).
module tb_pwm_sd_dac;
   localparam int DW     = 14;
   localparam int CW     = 8;
   localparam int PERIOD = 256;
   localparam int FRAME  = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 sync;
   logic signed [DW-1:0] dat;
   logic                 pwm;
   logic                 period;
   logic [CW:0]          duty;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // reference model state
   int m_cnt      = 0;
   int m_acc      = 0;
   int m_duty     = 0;
   int exp_pwm    = 0;
   int exp_period = 0;
   int m_u;
   int m_sum;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   pwm_sd_dac dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .dat_i    (dat),
      .sync_i   (sync),
      .pwm_o    (pwm),
      .period_o (period),
      .duty_o   (duty)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Position within the period, the period-start sample of the input
   // and a modulo-64 dither accumulator, in plain integer arithmetic.
   always @(posedge clk) begin
      if (rst || !sync) begin
         m_cnt      = 0;
         m_acc      = 0;
         m_duty     = 0;
         exp_pwm    = 0;
         exp_period = 0;
      end else begin
         exp_pwm    = (m_cnt < m_duty) ? 1 : 0;
         exp_period = (m_cnt == 0) ? 1 : 0;
         if (m_cnt == PERIOD - 1) begin
            m_u = dat;
            m_u = m_u + 8192;
`ifdef PWM_SD_DITHER_EN
            m_sum  = m_acc + (m_u % 64);
            m_duty = (m_u / 64) + ((m_sum >= 64) ? 1 : 0);
            m_acc  = m_sum % 64;
`else
            m_duty = m_u / 64;
`endif
         end
         m_cnt = (m_cnt + 1) % PERIOD;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("pwm_o", pwm, exp_pwm);
         check("period_o", period, exp_period);
         check("duty_o", duty, m_duty);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_period();
      if (period === 1'b1) return;
      for (int i = 0; i < 2 * PERIOD; i++) begin
         @(negedge clk);
         if (period === 1'b1) return;
      end
      check("period_timeout", period, 1);
   endtask

   // Measure one full period starting at the next period strobe.
   task automatic measure_period(output int highs, output int duty_seen);
      wait_period();
      duty_seen = duty;
      highs     = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         highs += (pwm === 1'b1) ? 1 : 0;
      end
   endtask

   int h, d, total, n_hi, n_lo;

   // ---------------- stimulus ----------------
   initial begin
      rst  = 1'b1;
      sync = 1'b1;
      dat  = '0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_pwm", pwm, 0);
      check("rst_period", period, 0);
      check("rst_duty", duty, 0);
      rst = 1'b0;

      // most negative input: always low, strobe every period
      dat = -14'sd8192;
      for (int p = 0; p < 5; p++) begin
         measure_period(h, d);
         check("neg_full_highs", h, 0);
      end

      // mid-scale: 128 high cycles per period
      dat = 14'sd0;
      measure_period(h, d);
      for (int p = 0; p < 2; p++) begin
         measure_period(h, d);
         check("mid_highs", h, 128);
         check("mid_duty", d, 128);
      end

      // fine = 32: frame total and duty alternation
      dat = 14'sd32;
      measure_period(h, d);
      total = 0; n_hi = 0; n_lo = 0;
      for (int p = 0; p < FRAME; p++) begin
         measure_period(h, d);
         check("fine32_highs_eq_duty", h, d);
         total += h;
         if (d == 129) n_hi++;
         if (d == 128) n_lo++;
      end
`ifdef PWM_SD_DITHER_EN
      check("fine32_total", total, 8224);
      check("fine32_n129", n_hi, 32);
      check("fine32_n128", n_lo, 32);
`else
      check("fine32_total", total, 8192);
      check("fine32_n128", n_lo, 64);
`endif

      // most positive input: full-high periods with dither
      dat = 14'sd8191;
      measure_period(h, d);
      n_hi = 0; n_lo = 0;
      for (int p = 0; p < FRAME; p++) begin
         measure_period(h, d);
         check("pos_full_highs_eq_duty", h, d);
         if (d == 256) n_hi++;
         if (d == 255) n_lo++;
      end
`ifdef PWM_SD_DITHER_EN
      check("pos_full_n256", n_hi, 63);
      check("pos_full_n255", n_lo, 1);
`else
      check("pos_full_n256", n_hi, 0);
      check("pos_full_n255", n_lo, 64);
`endif

      // input step mid-period: no effect until the next boundary
      dat = 14'sd0;
      measure_period(h, d);
      measure_period(h, d);
      wait_period();
      h = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i > 0) @(negedge clk);
         h += (pwm === 1'b1) ? 1 : 0;
         if (i == 99) dat = -14'sd4096;
      end
      check("step_cur_highs", h, 128);
      measure_period(h, d);
      check("step_next_highs", h, 64);
      check("step_next_duty", d, 64);

      // one-cycle reset mid-period at duty 128, then sync low for 3 cycles
      for (int k = 0; k < 2; k++) begin
         dat = 14'sd0;
         measure_period(h, d);
         measure_period(h, d);
         wait_period();
         repeat (49) @(negedge clk);
         if (k == 0) rst = 1'b1;
         else sync = 1'b0;
         repeat ((k == 0) ? 1 : 3) @(negedge clk);
         check("clr_pwm", pwm, 0);
         check("clr_period", period, 0);
         check("clr_duty", duty, 0);
         rst  = 1'b0;
         sync = 1'b1;
         @(negedge clk);
         check("rel_period", period, 1);
         measure_period(h, d);
         check("rel_first_highs", h, 0);
         measure_period(h, d);
         check("rel_second_highs", h, 128);
      end

      // randomized input changes, run-enable drops and resets
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 2) begin
            case ($urandom_range(0, 5))
               0:       dat = -14'sd8192;
               1:       dat = 14'sd8191;
               default: dat = 14'($urandom_range(0, 16383));
            endcase
         end
         if ($urandom_range(0, 999) == 0) begin
            sync = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            sync = 1'b1;
         end
         if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
